// File: rtl/alu_exec_unit_if.sv
// Issue and CDB handshake bundle for the integer execute unit.
// master = reservation station / CDB arbiter side, slave = execute unit.
interface alu_exec_unit_if #(
    parameter int ROB_IDX_W = 5
);
    logic                 issue_valid;
    logic                 issue_ready;
    logic [ROB_IDX_W-1:0] issue_rob_idx;
    logic                 issue_is_cmp;
    logic [2:0]           issue_aluop;
    logic [2:0]           issue_cmpop;
    logic                 issue_op1_sel;
    logic                 issue_op2_sel;
    logic [31:0]          issue_rs1_v;
    logic [31:0]          issue_rs2_v;
    logic [31:0]          issue_imm;
    logic [31:0]          issue_pc;
    logic                 cdb_req;
    logic                 cdb_grant;
    logic [ROB_IDX_W-1:0] cdb_rob_idx;
    logic [31:0]          cdb_value;

    modport master (
        output issue_valid, issue_rob_idx, issue_is_cmp, issue_aluop, issue_cmpop,
               issue_op1_sel, issue_op2_sel, issue_rs1_v, issue_rs2_v, issue_imm,
               issue_pc, cdb_grant,
        input  issue_ready, cdb_req, cdb_rob_idx, cdb_value
    );

    modport slave (
        input  issue_valid, issue_rob_idx, issue_is_cmp, issue_aluop, issue_cmpop,
               issue_op1_sel, issue_op2_sel, issue_rs1_v, issue_rs2_v, issue_imm,
               issue_pc, cdb_grant,
        output issue_ready, cdb_req, cdb_rob_idx, cdb_value
    );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I integer execute unit: combinational ALU/compare at issue, results
// queued in a small FIFO until the CDB arbiter grants a broadcast.
module alu_exec_unit #(
    parameter int ROB_IDX_W = 5,
    parameter int DEPTH     = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    alu_exec_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SLL = 3'b001, ALU_SRA = 3'b010, ALU_SUB = 3'b011,
        ALU_XOR = 3'b100, ALU_SRL = 3'b101, ALU_OR  = 3'b110, ALU_AND = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_BEQ = 3'b000, CMP_BNE = 3'b001, CMP_SLT  = 3'b010, CMP_SLTU = 3'b011,
        CMP_BLT = 3'b100, CMP_BGE = 3'b101, CMP_BLTU = 3'b110, CMP_BGEU = 3'b111
    } cmp_op_e;

    logic [31:0] op_a, op_b, alu_res, result;
    logic [4:0]  shamt;
    logic        cmp_bit, lt_s, lt_u, eq;

    always_comb begin
        op_a    = bus.issue_op1_sel ? bus.issue_pc  : bus.issue_rs1_v;
        op_b    = bus.issue_op2_sel ? bus.issue_imm : bus.issue_rs2_v;
        shamt   = op_b[4:0];
        lt_s    = $signed(op_a) < $signed(op_b);
        lt_u    = op_a < op_b;
        eq      = op_a == op_b;
        alu_res = '0;
        cmp_bit = 1'b0;
        case (alu_op_e'(bus.issue_aluop))
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SLL: alu_res = op_a << shamt;
            ALU_SRA: alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_SUB: alu_res = op_a - op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SRL: alu_res = op_a >> shamt;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_AND: alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
        case (cmp_op_e'(bus.issue_cmpop))
            CMP_BEQ:  cmp_bit = eq;
            CMP_BNE:  cmp_bit = !eq;
            CMP_SLT:  cmp_bit = lt_s;
            CMP_SLTU: cmp_bit = lt_u;
            CMP_BLT:  cmp_bit = lt_s;
            CMP_BGE:  cmp_bit = !lt_s;
            CMP_BLTU: cmp_bit = lt_u;
            CMP_BGEU: cmp_bit = !lt_u;
            default:  cmp_bit = 1'b0;
        endcase
        result = bus.issue_is_cmp ? {31'b0, cmp_bit} : alu_res;
    end

    logic [ROB_IDX_W-1:0] tag_mem [DEPTH];
    logic [31:0]          val_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 push, pop;

    // Ready depends on registered count only, so a same-cycle grant cannot
    // open a slot; push and pop together are therefore never seen when full.
    assign bus.issue_ready = count < CNT_FULL;
    assign bus.cdb_req     = count != '0;
    assign push = bus.issue_valid && bus.issue_ready && !flush;
    assign pop  = bus.cdb_req && bus.cdb_grant && !flush;

    assign bus.cdb_rob_idx = bus.cdb_req ? tag_mem[rd_ptr] : '0;
    assign bus.cdb_value   = bus.cdb_req ? val_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= bus.issue_rob_idx;
            val_mem[wr_ptr] <= result;
        end
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execute functional unit, downstream of the ALU reservation station and upstream of the common data bus (CDB) arbiter.
- Accepts one issued instruction per cycle and selects operands (register, PC or immediate).
- Computes an RV32I ALU or compare result and buffers it in a small result FIFO until the CDB arbiter grants a broadcast slot.
- Supports a full squash on pipeline flush.

Parameters:
- ROB_IDX_W, 5, width of the ROB tag carried with each result
- DEPTH, 2, result-buffer entries; power of two, at least 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  squash all buffered and incoming work this cycle
- issue_valid  in  1  reservation station offers an instruction
- issue_ready  out  1  unit can accept this cycle
- issue_rob_idx  in  ROB_IDX_W  destination ROB tag
- issue_is_cmp  in  1  0 = ALU op, 1 = compare op
- issue_aluop  in  3  add 000, sll 001, sra 010, sub 011, xor 100, srl 101, or 110, and 111
- issue_cmpop  in  3  beq 000, bne 001, slt 010, sltu 011, blt 100, bge 101, bltu 110, bgeu 111
- issue_op1_sel  in  1  0 = rs1_v, 1 = pc
- issue_op2_sel  in  1  0 = rs2_v, 1 = imm
- issue_rs1_v, issue_rs2_v, issue_imm, issue_pc  in  32 each  operand sources
- cdb_req  out  1  head entry valid, requesting broadcast
- cdb_grant  in  1  arbiter grants this unit this cycle
- cdb_rob_idx  out  ROB_IDX_W  head entry tag
- cdb_value  out  32  head entry result

Behaviour:
- Reset (async assert): FIFO empty, read/write pointers 0, count 0. cdb_req=0, cdb_rob_idx=0, cdb_value=0, issue_ready=1 once reset deasserts.
- Operand select: a = op1_sel ? pc : rs1_v; b = op2_sel ? imm : rs2_v.
- ALU ops, all mod 2^32:
  - add, sub, xor, or, and: standard.
  - sll and srl: shift amount b[4:0]; srl is logical.
  - sra: arithmetic right shift of signed a by b[4:0].
- Compare ops:
  - eq/ne are bitwise.
  - blt, bge, slt use signed compare; bltu, bgeu, sltu use unsigned.
  - Result is {31'b0, cmp_bit}.
- Unused opcode combinations do not exist; the field is fully decoded.
- Compute is combinational at issue. The accepted result is written to the FIFO tail at the clock edge where issue_valid && issue_ready && !flush.
- Latency: an instruction accepted at edge N appears at the head with cdb_req=1 in cycle N+1 when the FIFO was empty. Otherwise it appears in FIFO order.
- issue_ready = (count < DEPTH). It is registered-state only; there is no combinational path from cdb_grant.
- Pop occurs on cdb_req && cdb_grant at the clock edge. cdb_grant while cdb_req=0 is ignored.
- cdb_rob_idx and cdb_value are driven from the head entry. They hold stable while cdb_req=1 and no grant arrives.
- Outputs read 0 when the FIFO is empty.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal only when count < DEPTH at cycle start.
- Pointers wrap modulo DEPTH.
- Order: results leave in strict acceptance order; no reordering.
- flush: at that edge, count, pointers and all valid state clear. Any concurrent issue and grant are discarded. cdb_req=0 the following cycle and issue_ready=1.
- Reset asserted mid-operation empties the FIFO immediately (async). In-flight results are lost.

Test Plan:
- Reset, then issue add with rs1_v=0x0000_0005, rs2_v=0xFFFF_FFFF, sel=00, tag 3, grant held 1 → next cycle cdb_req=1, tag 3, value 0x0000_0004; cdb_req=0 afterwards.
- sra with rs1_v=0x8000_0000, imm=0x0000_0024, op2_sel=1 → value 0xF800_0000 (shamt 4). Same operands with srl → 0x0800_0000.
- Compare: blt with a=0xFFFF_FFFF, b=1 → value 1; bltu with the same operands → 0. Also pc=0x1000 with op1_sel=1, add imm 8 → value 0x0000_1008.
- Backpressure with grant=0, issue tags 1, 2, 3 back-to-back:
  - Tags 1 and 2 are accepted and issue_ready=0 at count=2.
  - Tag 3 is stalled.
  - Raise grant → outputs tag 1, then tag 2, then tag 3 in order.
- Simultaneous push/pop at count=1: issue tag 7 while grant=1 → head pops, count stays 1, tag 7 appears next. Verify pointer wrap over 6 such cycles.
- flush with count=2, issue_valid=1 and grant=1 in the same cycle → next cycle cdb_req=0, issue_ready=1, and neither the flushed nor the concurrent instruction ever appears. Also assert rst mid-stream → cdb_req drops without waiting for a clock edge.
